// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of digit steps per operation; guarded so a bad DIGIT still elaborates far enough to hit the fatal check.
   function automatic int num_digits(input int width, input int digit);
      return (digit < 1) ? 1 : width / digit;
   endfunction

   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = num_digits(width, digit);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/digit_bls.sv
// Combinational DIGIT-bit borrow-lookahead subtractor: d = a - b - bin.
module digit_bls #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout
);

   logic [DIGIT-1:0] g;
   logic [DIGIT-1:0] p;
   logic [DIGIT:0]   brw;
   logic             chain;
   logic             term;
   logic             acc;

   // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
   assign g = ~a & b;
   assign p = ~(a ^ b);

   // Each borrow is a flat sum of generate terms masked by the propagates above them.
   always_comb begin
      // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned, which would infer a latch.
      brw    = '0;
      brw[0] = bin;
      chain  = 1'b0;
      term   = 1'b0;
      acc    = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         chain = bin;
         for (int j = 0; j <= i; j++) chain = chain & p[j];
         acc = chain;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            acc = acc | term;
         end
         brw[i+1] = acc;
      end
   end

   assign d    = a ^ b ^ brw[DIGIT-1:0];
   assign bout = brw[DIGIT];

endmodule

// File: rtl/digit_serial_sub.sv
// Multi-cycle subtractor: Diff = X - Y - Bin, DIGIT bits per clock through one lookahead slice.
module digit_serial_sub
   import sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             V,
   output logic             Z
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(WIDTH, DIGIT);

   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $fatal(1, "digit_serial_sub: WIDTH must be a positive multiple of DIGIT");
   end

   state_t           state;
   logic [WIDTH-1:0] xs;
   logic [WIDTH-1:0] ys;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] wd_next;
   logic             brw;
   logic             x_sign;
   logic             y_sign;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] dig_d;
   logic             dig_b;
   logic             last_digit;

   digit_bls #(.DIGIT(DIGIT)) u_slice (
      .a    (xs[DIGIT-1:0]),
      .b    (ys[DIGIT-1:0]),
      .bin  (brw),
      .d    (dig_d),
      .bout (dig_b)
   );

   // Each new digit enters at the MSB end, so after N steps the word is in place.
   if (DIGIT == WIDTH) begin : g_single
      assign wd_next = dig_d;
   end else begin : g_multi
      assign wd_next = {dig_d, wd[WIDTH-1:DIGIT]};
   end

   assign last_digit = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         Diff   <= '0;
         Bout   <= 1'b0;
         V      <= 1'b0;
         Z      <= 1'b0;
         xs     <= '0;
         ys     <= '0;
         wd     <= '0;
         brw    <= 1'b0;
         x_sign <= 1'b0;
         y_sign <= 1'b0;
         cnt    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  xs     <= X;
                  ys     <= Y;
                  brw    <= Bin;
                  x_sign <= X[WIDTH-1];
                  y_sign <= Y[WIDTH-1];
                  wd     <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               xs  <= xs >> DIGIT;
               ys  <= ys >> DIGIT;
               brw <= dig_b;
               wd  <= wd_next;
               cnt <= cnt + 1'b1;
               if (last_digit) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  Diff  <= wd_next;
                  Bout  <= dig_b;
                  V     <= (x_sign != y_sign) && (wd_next[WIDTH-1] != x_sign);
                  Z     <= (wd_next == '0);
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/digit_serial_sub.md
Name: digit_serial_sub

Overview:
Parametrised multi-cycle subtractor computing Diff = X - Y - Bin over WIDTH bits. Processes DIGIT bits per clock through one borrow-lookahead digit slice, with the borrow registered between digits. Start/done handshake plus busy flag, so datapaths trade area for latency. Also reports borrow-out, signed overflow and zero flags.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; DIGIT == WIDTH gives single-cycle operation.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when not busy
X  input  WIDTH  minuend, captured on accepted start
Y  input  WIDTH  subtrahend, captured on accepted start
Bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse: results updated this cycle
Diff  output  WIDTH  result register, holds last completed result
Bout  output  1  borrow out of MSB of last result
V  output  1  signed overflow of last result
Z  output  1  last Diff == 0

Behaviour:
- N = WIDTH/DIGIT digit steps per operation.
- Reset (async assert, sync-released use): state IDLE, busy=0, done=0, Diff=0, Bout=0, V=0, Z=0, working regs and digit counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge -> capture X, Y into shift registers; capture Bin as running borrow; cnt=0; go RUN. start=0 -> stay.
- RUN: busy=1. Each edge: digit slice subtracts X[DIGIT-1:0] - Y[DIGIT-1:0] - borrow; digit result shifts into MSB end of working diff register; operands shift right by DIGIT; borrow register takes digit borrow-out; cnt++. Edge processing digit N-1 -> go DONE, load Diff, Bout, V, Z from final values.
- DONE: done=1, busy=0 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back, next result N+1 cycles later); otherwise -> IDLE.
- Latency: start accepted at edge k -> done high during cycle after edge k+N; throughput one op per N+1 cycles.
- start while busy: ignored, no effect on operands or results.
- Diff/Bout/V/Z change only on the edge entering DONE; stable otherwise, including during RUN.
- V = (X[WIDTH-1] != Y[WIDTH-1]) && (Diff[WIDTH-1] != X[WIDTH-1]) on captured operands; Bin included in the arithmetic.
- Bout = 1 iff unsigned X < Y + Bin.
- Wrap-around: result modulo 2^WIDTH; X=0, Y=0, Bin=1 -> Diff all ones, Bout=1.
- Reset mid-operation: immediately abort, all outputs to reset values, no done pulse.
- Elaboration check: WIDTH % DIGIT != 0 or DIGIT < 1 is a fatal error.

Decomposition:
- Package sub_pkg: state enum (IDLE, RUN, DONE); helper constant function computing N and counter width clog2(N) (minimum 1).
- Sub-module digit_bls: combinational DIGIT-bit borrow-lookahead subtractor (inputs a, b, bin; outputs d, bout), generate/propagate borrow form. Instantiated once; the same slice is also usable standalone.

Test Plan:
- WIDTH=16, DIGIT=4: X=0x0001, Y=0x000D, Bin=0, start 1 cycle -> busy 4 cycles, done 1 cycle, Diff=0xFFF4, Bout=1, V=0, Z=0.
- X=0xFFFF, Y=0xFFFF, Bin=1 -> Diff=0xFFFF, Bout=1, V=0, Z=0; X=0x5555, Y=0x5555, Bin=0 -> Diff=0x0000, Bout=0, Z=1.
- X=0x8000, Y=0x0001, Bin=0 -> Diff=0x7FFF, Bout=0, V=1; X=0x7FFF, Y=0xFFFF, Bin=0 -> Diff=0x8000, Bout=1, V=1.
- start pulsed again mid-RUN with different operands -> ignored, first result unchanged; start held high through DONE -> second op accepted, done pulses 5 cycles apart.
- rst_n low during RUN cycle 2 -> outputs zero at once, no done; next op after release correct.
- Exhaustive 4-bit X, Y, Bin with WIDTH=8 DIGIT=4 and WIDTH=4 DIGIT=4 (N=1) -> compare against golden X-Y-Bin each op.
